jpeg_decoder_bit_buffer: RTL and testbench

Bitstream reader on the read side of the JPEG decoder input FIFO. Each cycle it can pop one 32-bit word of the JPEG byte stream and remove 0xFF00 byte stuffing when enabled. Surviving bytes are packed into a 64-bit MSB-first shift buffer. The buffer presents a 32-bit peek window to the header parser and Huffman decoder, which consume a variable number of bits (1-32) per cycle.

---
 rtl/jpeg_decoder_bit_buffer_if.sv | 25 ++
 rtl/jpeg_decoder_bit_buffer.sv | 91 +++++++++
 tb/tb_jpeg_decoder_bit_buffer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_decoder_bit_buffer_if.sv
// Stream-side and consumer-side signals of the JPEG bit buffer.
// slave: the bit buffer itself; master: the FIFO/parser side driving it.
// Control flush_i rides with the bus so a new image resets both sides together.
interface jpeg_decoder_bit_buffer_if;
  logic        flush_i;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic        data_pop_o;
  logic        stuff_en_i;
  logic [31:0] bits_o;
  logic [6:0]  level_o;
  logic        consume_i;
  logic [5:0]  consume_bits_i;
  logic        underflow_o;

  modport slave (
    input  flush_i, data_i, data_valid_i, stuff_en_i, consume_i, consume_bits_i,
    output data_pop_o, bits_o, level_o, underflow_o
  );

  modport master (
    output flush_i, data_i, data_valid_i, stuff_en_i, consume_i, consume_bits_i,
    input  data_pop_o, bits_o, level_o, underflow_o
  );
endinterface

// File: rtl/jpeg_decoder_bit_buffer.sv
// Bit buffer: pops 32-bit FIFO words, strips FF00 stuffing, presents a 32-bit MSB-first peek window.
// Latency: a word popped or bits consumed in cycle N are visible in cycle N+1.
// Backpressure: pops only while 32 or fewer bits are held; pop never depends on same-cycle consume.
module jpeg_decoder_bit_buffer (
  input  logic                            clk_i,
  input  logic                            rst_i,
  jpeg_decoder_bit_buffer_if.slave        bus
);

  logic [63:0] buf_q, buf_d;
  logic [6:0]  level_q, level_d;
  logic        prev_ff_q, prev_ff_d;
  logic        underflow_q, underflow_d;

  logic        pop_w;
  logic [31:0] kept_w;
  logic [2:0]  kept_cnt_w;
  logic        pf_w;
  logic [7:0]  byte_w;
  logic [5:0]  cons_w;
  logic        under_w;
  logic [6:0]  rem_w;
  logic [63:0] base_w;

  // Room check uses registered level only; reset holds the pop low.
  assign pop_w = bus.data_valid_i & (level_q <= 7'd32) & ~bus.flush_i & ~rst_i;

  // Byte filter: walk bytes 0..3 in stream order, drop 00 after FF when stuffing is on,
  // and pack survivors MSB-justified.
  always_comb begin
    kept_w     = '0;
    kept_cnt_w = '0;
    pf_w       = prev_ff_q;
    byte_w     = '0;
    for (int i = 0; i < 4; i++) begin
      byte_w = bus.data_i[8*i +: 8];
      if (bus.stuff_en_i && pf_w && (byte_w == 8'h00)) begin
        pf_w = 1'b0;
      end else begin
        kept_w     = kept_w | ({byte_w, 24'h0} >> {kept_cnt_w, 3'b000});
        kept_cnt_w = kept_cnt_w + 3'd1;
        pf_w       = (byte_w == 8'hFF);
      end
    end
    if (!bus.stuff_en_i) pf_w = 1'b0;
  end

  // Next state: drop consumed bits first, then append kept bytes right after the remaining bits.
  always_comb begin
    cons_w  = bus.consume_i ? bus.consume_bits_i : 6'd0;
    under_w = ({1'b0, cons_w} > level_q);
    if (under_w) begin
      rem_w  = '0;
      base_w = '0;
    end else begin
      rem_w  = level_q - {1'b0, cons_w};
      base_w = buf_q << cons_w;
    end
    buf_d       = base_w | (pop_w ? ({kept_w, 32'h0} >> rem_w) : 64'h0);
    level_d     = rem_w + (pop_w ? {1'b0, kept_cnt_w, 3'b000} : 7'd0);
    prev_ff_d   = pop_w ? pf_w : prev_ff_q;
    underflow_d = underflow_q | under_w;
    if (bus.flush_i) begin
      buf_d       = '0;
      level_d     = '0;
      prev_ff_d   = 1'b0;
      underflow_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_q       <= '0;
      level_q     <= '0;
      prev_ff_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      level_q     <= level_d;
      prev_ff_q   <= prev_ff_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.data_pop_o  = pop_w;
  assign bus.bits_o      = buf_q[63:32];
  assign bus.level_o     = level_q;
  assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_jpeg_decoder_bit_buffer.sv
// Self-checking bench for jpeg_decoder_bit_buffer: directed scenarios plus a randomized run
// checked against a bit-queue reference model.
module tb_jpeg_decoder_bit_buffer;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  jpeg_decoder_bit_buffer_if bif ();

  jpeg_decoder_bit_buffer dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bif.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs;
    bif.flush_i        = 1'b0;
    bif.data_i         = 32'h0;
    bif.data_valid_i   = 1'b0;
    bif.stuff_en_i     = 1'b0;
    bif.consume_i      = 1'b0;
    bif.consume_bits_i = 6'd0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic do_flush;
    @(negedge clk_i);
    idle_inputs();
    bif.flush_i = 1'b1;
    @(negedge clk_i);
    bif.flush_i = 1'b0;
  endtask

  // One-cycle pop of a word, returning at the next negedge with inputs idle.
  task automatic push_word(input logic [31:0] w, input logic stuff);
    bif.data_i       = w;
    bif.stuff_en_i   = stuff;
    bif.data_valid_i = 1'b1;
    @(negedge clk_i);
    bif.data_valid_i = 1'b0;
  endtask

  task automatic consume(input int n);
    bif.consume_i      = 1'b1;
    bif.consume_bits_i = 6'(n);
    @(negedge clk_i);
    bif.consume_i      = 1'b0;
    bif.consume_bits_i = 6'd0;
  endtask

  task automatic test_reset;
    do_reset();
    push_word(32'h44332211, 1'b0);
    // Asynchronous reset mid-operation with a word waiting.
    bif.data_valid_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if (bif.level_o !== 7'd0) begin n_fail++; $display("FAIL reset_level actual=%0d required=0", bif.level_o); end
    n_checks++; if (bif.bits_o !== 32'h0) begin n_fail++; $display("FAIL reset_bits actual=%h required=00000000", bif.bits_o); end
    n_checks++; if (bif.underflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_underflow actual=%b required=0", bif.underflow_o); end
    n_checks++; if (bif.data_pop_o !== 1'b0) begin n_fail++; $display("FAIL reset_pop actual=%b required=0", bif.data_pop_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_checks++; if (bif.data_pop_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_pop actual=%b required=1", bif.data_pop_o); end
    bif.data_valid_i = 1'b0;
  endtask

  task automatic test_plain_load;
    do_flush();
    bif.data_i       = 32'h44332211;
    bif.stuff_en_i   = 1'b0;
    bif.data_valid_i = 1'b1;
    #1;
    n_checks++; if (bif.data_pop_o !== 1'b1) begin n_fail++; $display("FAIL plain_pop actual=%b required=1", bif.data_pop_o); end
    @(negedge clk_i);
    bif.data_valid_i = 1'b0;
    n_checks++; if (bif.level_o !== 7'd32) begin n_fail++; $display("FAIL plain_level actual=%0d required=32", bif.level_o); end
    n_checks++; if (bif.bits_o !== 32'h11223344) begin n_fail++; $display("FAIL plain_bits actual=%h required=11223344", bif.bits_o); end
  endtask

  task automatic test_cross_word_stuffing;
    do_flush();
    push_word(32'hFFEFCDAB, 1'b1);
    n_checks++; if (bif.level_o !== 7'd32) begin n_fail++; $display("FAIL stuff_w1_level actual=%0d required=32", bif.level_o); end
    n_checks++; if (bif.bits_o !== 32'hABCDEFFF) begin n_fail++; $display("FAIL stuff_w1_bits actual=%h required=abcdefff", bif.bits_o); end
    push_word(32'h33221100, 1'b1);
    n_checks++; if (bif.level_o !== 7'd56) begin n_fail++; $display("FAIL stuff_w2_level actual=%0d required=56", bif.level_o); end
    consume(32);
    n_checks++; if (bif.bits_o !== 32'h11223300) begin n_fail++; $display("FAIL stuff_cons_bits actual=%h required=11223300", bif.bits_o); end
    n_checks++; if (bif.level_o !== 7'd24) begin n_fail++; $display("FAIL stuff_cons_level actual=%0d required=24", bif.level_o); end
    bif.stuff_en_i = 1'b0;
  endtask

  task automatic test_backpressure;
    do_flush();
    push_word(32'h44332211, 1'b0);
    push_word(32'h88776655, 1'b0);
    consume(24);
    n_checks++; if (bif.level_o !== 7'd40) begin n_fail++; $display("FAIL bp_level40 actual=%0d required=40", bif.level_o); end
    bif.data_i       = 32'h0;
    bif.data_valid_i = 1'b1;
    #1;
    n_checks++; if (bif.data_pop_o !== 1'b0) begin n_fail++; $display("FAIL bp_pop_blocked actual=%b required=0", bif.data_pop_o); end
    bif.consume_i      = 1'b1;
    bif.consume_bits_i = 6'd16;
    @(negedge clk_i);
    bif.consume_i = 1'b0;
    #1;
    n_checks++; if (bif.level_o !== 7'd24) begin n_fail++; $display("FAIL bp_level24 actual=%0d required=24", bif.level_o); end
    n_checks++; if (bif.bits_o !== 32'h66778800) begin n_fail++; $display("FAIL bp_bits actual=%h required=66778800", bif.bits_o); end
    n_checks++; if (bif.data_pop_o !== 1'b1) begin n_fail++; $display("FAIL bp_pop_resumed actual=%b required=1", bif.data_pop_o); end
    bif.data_valid_i = 1'b0;
  endtask

  task automatic test_simultaneous;
    do_flush();
    push_word(32'hA5A5A5CC, 1'b0);
    consume(8);
    n_checks++; if (bif.bits_o !== 32'hA5A5A500) begin n_fail++; $display("FAIL sim_setup_bits actual=%h required=a5a5a500", bif.bits_o); end
    bif.consume_i      = 1'b1;
    bif.consume_bits_i = 6'd8;
    push_word(32'h04030201, 1'b0);
    bif.consume_i = 1'b0;
    n_checks++; if (bif.level_o !== 7'd48) begin n_fail++; $display("FAIL sim_level actual=%0d required=48", bif.level_o); end
    n_checks++; if (bif.bits_o !== 32'hA5A50102) begin n_fail++; $display("FAIL sim_bits actual=%h required=a5a50102", bif.bits_o); end
  endtask

  task automatic test_underflow_flush;
    do_flush();
    push_word(32'h000000EE, 1'b0);
    consume(24);
    n_checks++; if (bif.level_o !== 7'd8) begin n_fail++; $display("FAIL uf_setup_level actual=%0d required=8", bif.level_o); end
    consume(12);
    n_checks++; if (bif.level_o !== 7'd0) begin n_fail++; $display("FAIL uf_level actual=%0d required=0", bif.level_o); end
    n_checks++; if (bif.underflow_o !== 1'b1) begin n_fail++; $display("FAIL uf_set actual=%b required=1", bif.underflow_o); end
    repeat (3) @(negedge clk_i);
    n_checks++; if (bif.underflow_o !== 1'b1) begin n_fail++; $display("FAIL uf_sticky actual=%b required=1", bif.underflow_o); end
    bif.data_valid_i = 1'b1;
    bif.flush_i      = 1'b1;
    #1;
    n_checks++; if (bif.data_pop_o !== 1'b0) begin n_fail++; $display("FAIL flush_pop actual=%b required=0", bif.data_pop_o); end
    @(negedge clk_i);
    bif.flush_i      = 1'b0;
    bif.data_valid_i = 1'b0;
    n_checks++; if (bif.underflow_o !== 1'b0) begin n_fail++; $display("FAIL flush_underflow actual=%b required=0", bif.underflow_o); end
    n_checks++; if (bif.level_o !== 7'd0) begin n_fail++; $display("FAIL flush_level actual=%0d required=0", bif.level_o); end
  endtask

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // Reference model: the buffer is a plain queue of stream bits.
  task automatic test_random;
    bit          q[$];
    bit          pf;
    bit          uf;
    logic [31:0] exp_bits;
    logic        exp_pop;
    logic [7:0]  b;
    int          c;
    int          errs_before;
    do_reset();
    pf = 1'b0;
    uf = 1'b0;
    errs_before = n_fail;
    for (int cyc = 0; cyc < 3000 && (n_fail - errs_before) < 10; cyc++) begin
      @(negedge clk_i);
      exp_bits = '0;
      for (int i = 0; i < 32; i++) if (i < q.size()) exp_bits[31-i] = q[i];
      n_checks++; if (bif.level_o !== 7'(q.size())) begin n_fail++; $display("FAIL rnd_level cyc=%0d actual=%0d required=%0d", cyc, bif.level_o, q.size()); end
      n_checks++; if (bif.bits_o !== exp_bits) begin n_fail++; $display("FAIL rnd_bits cyc=%0d actual=%h required=%h", cyc, bif.bits_o, exp_bits); end
      n_checks++; if (bif.underflow_o !== uf) begin n_fail++; $display("FAIL rnd_underflow cyc=%0d actual=%b required=%b", cyc, bif.underflow_o, uf); end

      bif.flush_i        = ($urandom_range(0, 63) == 0);
      bif.data_valid_i   = ($urandom_range(0, 3) != 0);
      bif.data_i         = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
      bif.stuff_en_i     = ($urandom_range(0, 7) != 0);
      bif.consume_i      = ($urandom_range(0, 3) != 0);
      bif.consume_bits_i = 6'($urandom_range(0, 32));
      #1;
      exp_pop = bif.data_valid_i && (q.size() <= 32) && !bif.flush_i;
      n_checks++; if (bif.data_pop_o !== exp_pop) begin n_fail++; $display("FAIL rnd_pop cyc=%0d actual=%b required=%b", cyc, bif.data_pop_o, exp_pop); end

      if (bif.flush_i) begin
        q.delete();
        pf = 1'b0;
        uf = 1'b0;
      end else begin
        c = bif.consume_i ? int'(bif.consume_bits_i) : 0;
        if (c > q.size()) begin
          q.delete();
          uf = 1'b1;
        end else begin
          repeat (c) void'(q.pop_front());
        end
        if (exp_pop) begin
          for (int k = 0; k < 4; k++) begin
            b = bif.data_i[8*k +: 8];
            if (bif.stuff_en_i && pf && b == 8'h00) begin
              pf = 1'b0;
            end else begin
              for (int j = 7; j >= 0; j--) q.push_back(b[j]);
              pf = (b == 8'hFF);
            end
          end
          if (!bif.stuff_en_i) pf = 1'b0;
        end
      end
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_plain_load();
    test_cross_word_stuffing();
    test_backpressure();
    test_simultaneous();
    test_underflow_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
